// File: rtl/mlp_weight_loader.sv
// rtl/mlp_weight_loader.sv - Streams MLP parameters into the fc1/fc2 weight and bias memories
// Tracks region and offset, writes through one registered port, and checks length against s_last.
module mlp_weight_loader #(
    parameter int HIDDEN_DIM = 768,
    parameter int MLP_DIM    = 3072,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    output logic                  wr_en_o,
    output logic [1:0]            wr_sel_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_len_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W1,
        ST_LOAD_B1,
        ST_LOAD_W2,
        ST_LOAD_B2,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] W1_LAST = ADDR_WIDTH'(HIDDEN_DIM * MLP_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] B1_LAST = ADDR_WIDTH'(MLP_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] W2_LAST = ADDR_WIDTH'(MLP_DIM * HIDDEN_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] B2_LAST = ADDR_WIDTH'(HIDDEN_DIM - 1);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   off_q;
    logic [ADDR_WIDTH-1:0]   off_d;
    logic                    wr_en_q;
    logic [1:0]              wr_sel_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic                    done_q;
    logic                    err_len_q;

    logic                    in_load;
    logic [1:0]              region_sel;
    logic [ADDR_WIDTH-1:0]   region_last;
    state_t                  next_region;
    logic                    accept;
    logic                    region_end;
    logic                    final_word;

    // Per-region decode; B2 falls through to DRAIN when its last word arrives without s_last.
    always_comb begin
        in_load     = 1'b0;
        region_sel  = 2'd0;
        region_last = '0;
        next_region = ST_IDLE;
        case (state_q)
            ST_LOAD_W1: begin
                in_load     = 1'b1;
                region_sel  = 2'd0;
                region_last = W1_LAST;
                next_region = ST_LOAD_B1;
            end
            ST_LOAD_B1: begin
                in_load     = 1'b1;
                region_sel  = 2'd1;
                region_last = B1_LAST;
                next_region = ST_LOAD_W2;
            end
            ST_LOAD_W2: begin
                in_load     = 1'b1;
                region_sel  = 2'd2;
                region_last = W2_LAST;
                next_region = ST_LOAD_B2;
            end
            ST_LOAD_B2: begin
                in_load     = 1'b1;
                region_sel  = 2'd3;
                region_last = B2_LAST;
                next_region = ST_DRAIN;
            end
            default: begin
                in_load     = 1'b0;
            end
        endcase
    end

    assign s_ready_o  = in_load || (state_q == ST_DRAIN);
    assign accept     = s_valid_i && s_ready_o;
    assign region_end = (off_q == region_last);
    assign final_word = (state_q == ST_LOAD_B2) && region_end;
    assign off_d      = region_end ? '0 : off_q + ADDR_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            off_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= 2'd0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_LOAD_W1;
                        off_q   <= '0;
                    end
                end
                ST_LOAD_W1, ST_LOAD_B1, ST_LOAD_W2, ST_LOAD_B2: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_sel_q  <= region_sel;
                        wr_addr_q <= off_q;
                        wr_data_q <= s_data_i;
                        off_q     <= off_d;
                        if (s_last_i) begin
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                            err_len_q <= !final_word;
                        end else if (region_end) begin
                            state_q <= next_region;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept && s_last_i) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        err_len_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_sel_o  = wr_sel_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign done_o    = done_q;
    assign err_len_o = err_len_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mlp_weight_loader.sv
// tb/tb_mlp_weight_loader.sv - Self-checking bench for mlp_weight_loader (small 2x3 configuration)
module tb_mlp_weight_loader;

    localparam int HD    = 2;
    localparam int MD    = 3;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int TOTAL = 2 * HD * MD + MD + HD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          s_valid_i = 1'b0;
    logic [DW-1:0] s_data_i = '0;
    logic          s_last_i = 1'b0;
    logic          s_ready_o;
    logic          wr_en_o;
    logic [1:0]    wr_sel_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          busy_o;
    logic          done_o;
    logic          err_len_o;

    mlp_weight_loader #(
        .HIDDEN_DIM(HD),
        .MLP_DIM   (MD),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .s_valid_i(s_valid_i),
        .s_data_i (s_data_i),
        .s_last_i (s_last_i),
        .s_ready_o(s_ready_o),
        .wr_en_o  (wr_en_o),
        .wr_sel_o (wr_sel_o),
        .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_len_o(err_len_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           obs_q[$];
    wr_t           exp_q[$];
    int            obs_cyc[$];
    int            exp_cyc[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_done;
    int            done_cyc;
    int            stray_err;
    int            last_acc_cyc;
    logic          done_err;
    logic          done_wr;
    logic [DW-1:0] done_data;
    logic          busy_after_done;
    logic          prev_done;
    logic          last_busy;
    logic          last_ready;

    // Reference: a flat beat index maps onto (region, offset) by cumulative region lengths.
    function automatic void region_of(input int k, output logic [1:0] sel, output logic [AW-1:0] addr);
        int lens[4];
        int base;
        lens = '{HD * MD, MD, MD * HD, HD};
        base = 0;
        sel  = 2'd0;
        addr = '0;
        for (int r = 0; r < 4; r++) begin
            if (k >= base && k < base + lens[r]) begin
                sel  = 2'(r);
                addr = AW'(k - base);
            end
            base += lens[r];
        end
    endfunction

    task automatic step(input logic st, input logic v, input logic [DW-1:0] d, input logic l,
                        output logic acc);
        @(posedge clk);
        cyc++;
        #1;
        start_i   = st;
        s_valid_i = v;
        s_data_i  = d;
        s_last_i  = l;
        @(negedge clk);
        if (prev_done) busy_after_done = busy_o;
        prev_done = done_o;
        if (wr_en_o) begin
            obs_q.push_back({wr_sel_o, wr_addr_o, wr_data_o});
            obs_cyc.push_back(cyc);
        end
        if (done_o) begin
            n_done++;
            done_cyc  = cyc;
            done_err  = err_len_o;
            done_wr   = wr_en_o;
            done_data = wr_data_o;
        end
        if (err_len_o && !done_o) stray_err++;
        last_busy  = busy_o;
        last_ready = s_ready_o;
        acc        = v && s_ready_o;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
        exp_cyc.delete();
        n_done          = 0;
        stray_err       = 0;
        done_cyc        = -1;
        done_err        = 1'b0;
        done_wr         = 1'b0;
        done_data       = '0;
        busy_after_done = 1'b1;
        prev_done       = 1'b0;
        last_acc_cyc    = -2;
    endtask

    // gap_mode: 0 back-to-back, 1 alternating valid, 2 random idle cycles between beats.
    task automatic do_load(input int nbeats, input int last_at, input int gap_mode,
                           input int start_at, input bit rnd);
        logic          acc;
        logic [DW-1:0] d;
        logic [1:0]    sel;
        logic [AW-1:0] addr;
        int            tries;
        clear_obs();
        step(1'b1, 1'b0, '0, 1'b0, acc);
        for (int b = 1; b <= nbeats; b++) begin
            if (gap_mode == 1 && b > 1) step(1'b0, 1'b0, '0, 1'b0, acc);
            if (gap_mode == 2) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, '0, 1'b0, acc);
            d     = rnd ? DW'($urandom) : DW'(b);
            tries = 0;
            do begin
                step(b == start_at, 1'b1, d, b == last_at, acc);
                tries++;
            end while (!acc && tries < 8);
            if (!acc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: beat %0d got s_ready=0 want 1", b);
                break;
            end
            if (b <= TOTAL) begin
                region_of(b - 1, sel, addr);
                exp_q.push_back({sel, addr, d});
                exp_cyc.push_back(cyc + 1);
            end
            last_acc_cyc = cyc + 1;
            if (b == last_at) break;
        end
        repeat (4) step(1'b0, 1'b0, '0, 1'b0, acc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({wr_en_o, done_o, err_len_o, busy_o, s_ready_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {wr_en_o, done_o, err_len_o, busy_o, s_ready_o});
        end
        n_cmp++;
        if ({wr_sel_o, wr_addr_o, wr_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got sel=%0d addr=%0d data=%0h want 0", wr_sel_o, wr_addr_o, wr_data_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_stream();
        do_load(TOTAL, TOTAL, 0, 0, 1'b0);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL full_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k] || obs_cyc[k] !== exp_cyc[k]) begin
                n_fail++;
                $display("FAIL full_write[%0d]: got sel=%0d addr=%0d data=%0d cyc=%0d want sel=%0d addr=%0d data=%0d cyc=%0d",
                         k, obs_q[k].sel, obs_q[k].addr, obs_q[k].data, obs_cyc[k],
                         exp_q[k].sel, exp_q[k].addr, exp_q[k].data, exp_cyc[k]);
            end
        end
        n_cmp++;
        if (n_done !== 1 || done_err !== 1'b0 || stray_err !== 0) begin
            n_fail++;
            $display("FAIL full_done: got done=%0d err=%b stray=%0d want 1 0 0", n_done, done_err, stray_err);
        end
        n_cmp++;
        if (done_wr !== 1'b1 || done_data !== DW'(TOTAL) || done_cyc !== last_acc_cyc) begin
            n_fail++;
            $display("FAIL full_done_timing: got wr=%b data=%0d cyc=%0d want 1 %0d %0d",
                     done_wr, done_data, done_cyc, TOTAL, last_acc_cyc);
        end
        n_cmp++;
        if (busy_after_done !== 1'b0 || last_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_idle: got busy=%b ready=%b want 0 0", busy_after_done, last_ready);
        end
    endtask

    task automatic test_gaps();
        do_load(TOTAL, TOTAL, 1, 0, 1'b0);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL gaps_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k] || obs_cyc[k] !== exp_cyc[k]) begin
                n_fail++;
                $display("FAIL gaps_write[%0d]: got sel=%0d addr=%0d data=%0d cyc=%0d want sel=%0d addr=%0d data=%0d cyc=%0d",
                         k, obs_q[k].sel, obs_q[k].addr, obs_q[k].data, obs_cyc[k],
                         exp_q[k].sel, exp_q[k].addr, exp_q[k].data, exp_cyc[k]);
            end
        end
        n_cmp++;
        if (n_done !== 1 || done_err !== 1'b0 || done_cyc !== last_acc_cyc) begin
            n_fail++;
            $display("FAIL gaps_done: got done=%0d err=%b cyc=%0d want 1 0 %0d", n_done, done_err, done_cyc, last_acc_cyc);
        end
    endtask

    task automatic test_early_last();
        do_load(TOTAL, 8, 0, 0, 1'b1);
        n_cmp++;
        if (obs_q.size() !== 8 || exp_q.size() !== 8) begin
            n_fail++;
            $display("FAIL early_count: got %0d writes want 8", obs_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k] || obs_cyc[k] !== exp_cyc[k]) begin
                n_fail++;
                $display("FAIL early_write[%0d]: got sel=%0d addr=%0d data=%0h want sel=%0d addr=%0d data=%0h",
                         k, obs_q[k].sel, obs_q[k].addr, obs_q[k].data, exp_q[k].sel, exp_q[k].addr, exp_q[k].data);
            end
        end
        n_cmp++;
        if (n_done !== 1 || done_err !== 1'b1 || done_wr !== 1'b1 || done_cyc !== last_acc_cyc) begin
            n_fail++;
            $display("FAIL early_done: got done=%0d err=%b wr=%b cyc=%0d want 1 1 1 %0d",
                     n_done, done_err, done_wr, done_cyc, last_acc_cyc);
        end
        n_cmp++;
        if (last_busy !== 1'b0 || last_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL early_idle: got busy=%b ready=%b want 0 0", last_busy, last_ready);
        end
    endtask

    task automatic test_missing_last();
        do_load(TOTAL + 3, TOTAL + 3, 0, 0, 1'b1);
        n_cmp++;
        if (obs_q.size() !== TOTAL) begin
            n_fail++;
            $display("FAIL drain_count: got %0d writes want %0d", obs_q.size(), TOTAL);
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k] || obs_cyc[k] !== exp_cyc[k]) begin
                n_fail++;
                $display("FAIL drain_write[%0d]: got sel=%0d addr=%0d data=%0h want sel=%0d addr=%0d data=%0h",
                         k, obs_q[k].sel, obs_q[k].addr, obs_q[k].data, exp_q[k].sel, exp_q[k].addr, exp_q[k].data);
            end
        end
        n_cmp++;
        if (n_done !== 1 || done_err !== 1'b1 || done_wr !== 1'b0 || done_cyc !== last_acc_cyc) begin
            n_fail++;
            $display("FAIL drain_done: got done=%0d err=%b wr=%b cyc=%0d want 1 1 0 %0d",
                     n_done, done_err, done_wr, done_cyc, last_acc_cyc);
        end
    endtask

    task automatic test_reset_mid();
        logic acc;
        clear_obs();
        step(1'b1, 1'b0, '0, 1'b0, acc);
        for (int b = 1; b <= 11; b++) step(1'b0, 1'b1, DW'(b), 1'b0, acc);
        @(posedge clk);
        #2;
        n_cmp++;
        if (wr_en_o !== 1'b1 || wr_sel_o !== 2'd2 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: got wr=%b sel=%0d busy=%b want 1 2 1", wr_en_o, wr_sel_o, busy_o);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({wr_en_o, done_o, err_len_o, busy_o, s_ready_o, wr_sel_o, wr_addr_o, wr_data_o} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got wr=%b done=%b err=%b busy=%b ready=%b sel=%0d addr=%0d data=%0h want all 0",
                     wr_en_o, done_o, err_len_o, busy_o, s_ready_o, wr_sel_o, wr_addr_o, wr_data_o);
        end
        s_valid_i = 1'b0;
        start_i   = 1'b0;
        s_last_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_load(TOTAL, TOTAL, 0, 0, 1'b1);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k] || obs_cyc[k] !== exp_cyc[k]) begin
                n_fail++;
                $display("FAIL midreset_write[%0d]: got sel=%0d addr=%0d data=%0h want sel=%0d addr=%0d data=%0h",
                         k, obs_q[k].sel, obs_q[k].addr, obs_q[k].data, exp_q[k].sel, exp_q[k].addr, exp_q[k].data);
            end
        end
        n_cmp++;
        if (n_done !== 1 || done_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_done: got done=%0d err=%b want 1 0", n_done, done_err);
        end
    endtask

    task automatic test_start_in_b1();
        do_load(TOTAL, TOTAL, 0, 8, 1'b1);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL restart_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k] || obs_cyc[k] !== exp_cyc[k]) begin
                n_fail++;
                $display("FAIL restart_write[%0d]: got sel=%0d addr=%0d data=%0h want sel=%0d addr=%0d data=%0h",
                         k, obs_q[k].sel, obs_q[k].addr, obs_q[k].data, exp_q[k].sel, exp_q[k].addr, exp_q[k].data);
            end
        end
        n_cmp++;
        if (n_done !== 1 || done_err !== 1'b0 || stray_err !== 0) begin
            n_fail++;
            $display("FAIL restart_done: got done=%0d err=%b stray=%0d want 1 0 0", n_done, done_err, stray_err);
        end
    endtask

    task automatic test_random();
        int   last_at;
        int   nwr;
        logic exp_err;
        for (int it = 0; it < 6; it++) begin
            last_at = $urandom_range(1, TOTAL + 3);
            nwr     = (last_at < TOTAL) ? last_at : TOTAL;
            exp_err = (last_at != TOTAL);
            do_load(last_at, last_at, 2, 0, 1'b1);
            n_cmp++;
            if (obs_q.size() !== nwr) begin
                n_fail++;
                $display("FAIL rand%0d_count: last_at=%0d got %0d writes want %0d", it, last_at, obs_q.size(), nwr);
            end
            for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
                n_cmp++;
                if (obs_q[k] !== exp_q[k] || obs_cyc[k] !== exp_cyc[k]) begin
                    n_fail++;
                    $display("FAIL rand%0d_write[%0d]: got sel=%0d addr=%0d data=%0h cyc=%0d want sel=%0d addr=%0d data=%0h cyc=%0d",
                             it, k, obs_q[k].sel, obs_q[k].addr, obs_q[k].data, obs_cyc[k],
                             exp_q[k].sel, exp_q[k].addr, exp_q[k].data, exp_cyc[k]);
                end
            end
            n_cmp++;
            if (n_done !== 1 || done_err !== exp_err || done_cyc !== last_acc_cyc || stray_err !== 0) begin
                n_fail++;
                $display("FAIL rand%0d_done: last_at=%0d got done=%0d err=%b cyc=%0d want 1 %b %0d",
                         it, last_at, n_done, done_err, done_cyc, exp_err, last_acc_cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_gaps();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        test_start_in_b1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
